// File: rtl/carry_lookahead_16_pkg.sv
// Shared constants and helpers for the 16-bit two-level carry-lookahead adder.
// Width and group size are fixed; the derived group count sizes the second level.
package carry_lookahead_16_pkg;

  localparam int WIDTH      = 16;
  localparam int GROUP      = 4;
  localparam int NUM_GROUPS = WIDTH / GROUP;

  typedef logic [WIDTH-1:0]      word_t;
  typedef logic [GROUP-1:0]      nibble_t;
  typedef logic [NUM_GROUPS-1:0] grp_vec_t;

  // Lookahead carry into position k+1 of a 4-wide (p, g) vector.
  // Written as flat sum-of-products so no carry ripples through positions.
  function automatic grp_vec_t lookahead4(input grp_vec_t p,
                                          input grp_vec_t g,
                                          input logic     cin);
    grp_vec_t c;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

endpackage

// File: rtl/carry_lookahead_16_cla_4bit.sv
// One 4-bit lookahead group: bit carries from p/g and the group carry-in,
// plus group propagate/generate for the second-level lookahead.
module cla_4bit
  import carry_lookahead_16_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             P,
  output logic             G
);

  nibble_t p;
  nibble_t g;
  nibble_t c_out;
  nibble_t c_in;

  assign p = a ^ b;
  assign g = a & b;

  assign c_out = lookahead4(p, g, cin);
  assign c_in  = {c_out[2:0], cin};

  assign sum = p ^ c_in;

  // Group terms are independent of cin, which keeps the second level loop-free.
  assign P = &p;
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/carry_lookahead_16.sv
// 16-bit adder built from four 4-bit lookahead groups and a second-level
// group-carry lookahead, with a single registered output stage.
module carry_lookahead_16
  import carry_lookahead_16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_0,
  output logic [WIDTH-1:0] s,
  output logic             c_16
);

  grp_vec_t grp_p;
  grp_vec_t grp_g;
  grp_vec_t grp_cout;
  grp_vec_t grp_cin;
  word_t    sum_comb;

  for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_grp
    cla_4bit u_cla (
      .a   (a[k*GROUP +: GROUP]),
      .b   (b[k*GROUP +: GROUP]),
      .cin (grp_cin[k]),
      .sum (sum_comb[k*GROUP +: GROUP]),
      .P   (grp_p[k]),
      .G   (grp_g[k])
    );
  end

  // grp_cout = {c16, c12, c8, c4}, each a flat function of group P/G and c_0.
  assign grp_cout = lookahead4(grp_p, grp_g, c_0);
  assign grp_cin  = {grp_cout[2:0], c_0};

  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= '0;
      c_16 <= 1'b0;
    end else begin
      s    <= sum_comb;
      c_16 <= grp_cout[3];
    end
  end

endmodule

// File: tb/tb_carry_lookahead_16.sv
// Self-checking bench: expected 17-bit results are queued when operands are
// driven and compared one edge later against {c_16, s}.
module tb_carry_lookahead_16;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_0;
  logic [15:0] s;
  logic        c_16;

  int vectors;
  int miscompares;
  logic [16:0] exp_q[$];

  carry_lookahead_16 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .c_0  (c_0),
    .s    (s),
    .c_16 (c_16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  // Drive operands mid-cycle and queue the reference result for the next edge.
  task automatic drive(input logic r, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv);
    logic [16:0] exp_v;
    @(negedge clk);
    rst = r;
    a   = av;
    b   = bv;
    c_0 = cv;
    exp_v = r ? 17'h0 : ({1'b0, av} + {1'b0, bv} + {16'h0, cv});
    exp_q.push_back(exp_v);
  endtask

  task automatic test_reset();
    logic [16:0] exp_v;
    drive(1'b1, 16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    vectors++;
    if ({c_16, s} !== exp_v) begin
      miscompares++;
      $display("FAIL reset: got c_16=%b s=%h, want c_16=%b s=%h", c_16, s, exp_v[16], exp_v[15:0]);
    end
    // Reset must win even when the sum would carry out.
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    vectors++;
    if ({c_16, s} !== exp_v) begin
      miscompares++;
      $display("FAIL reset_priority: got c_16=%b s=%h, want c_16=%b s=%h", c_16, s, exp_v[16], exp_v[15:0]);
    end
  endtask

  task automatic test_directed();
    logic [16:0] exp_v;
    logic [16:0] lit;
    logic [15:0] av [12];
    logic [15:0] bv [12];
    logic        cv [12];
    logic [16:0] want [12];
    av = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0F0F, 16'hFFFF, 16'hAAAA,
           16'h000F, 16'h00FF, 16'h0FFF, 16'h7FFF, 16'h8000, 16'h1234};
    bv = '{16'h0000, 16'h0000, 16'hFFFF, 16'h00F1, 16'h0001, 16'h5555,
           16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h8000, 16'h1111};
    cv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    // Hand-computed results, checked against the queued model as well.
    want = '{17'h00000, 17'h10000, 17'h1FFFF, 17'h01000, 17'h10000, 17'h10000,
             17'h00010, 17'h00100, 17'h01000, 17'h10000, 17'h10000, 17'h02346};
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, av[i], bv[i], cv[i]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      lit   = want[i];
      vectors++;
      if ({c_16, s} !== exp_v || exp_v !== lit) begin
        miscompares++;
        $display("FAIL directed[%0d] a=%h b=%h c_0=%b: got c_16=%b s=%h, want %h",
                 i, av[i], bv[i], cv[i], c_16, s, lit);
      end
    end
  endtask

  task automatic test_reset_release();
    logic [16:0] exp_v;
    drive(1'b0, 16'h4321, 16'h0F0F, 1'b1);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    // Mid-stream reset discards the in-flight result.
    drive(1'b1, 16'hF00F, 16'h0FF1, 1'b1);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    vectors++;
    if ({c_16, s} !== exp_v) begin
      miscompares++;
      $display("FAIL midstream_reset: got c_16=%b s=%h, want %h", c_16, s, exp_v);
    end
    // First edge with rst low reflects inputs sampled at that edge.
    drive(1'b0, 16'hF00F, 16'h0FF1, 1'b1);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    vectors++;
    if ({c_16, s} !== exp_v) begin
      miscompares++;
      $display("FAIL reset_release: got c_16=%b s=%h, want %h", c_16, s, exp_v);
    end
    // Unchanged inputs: output holds.
    drive(1'b0, 16'hF00F, 16'h0FF1, 1'b1);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    vectors++;
    if ({c_16, s} !== exp_v) begin
      miscompares++;
      $display("FAIL hold: got c_16=%b s=%h, want %h", c_16, s, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_v;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    ra = '0; rb = '0; rc = 1'b0;
    // Pipelined: drive the next vector before checking the previous one.
    drive(1'b0, ra, rb, rc);
    for (int i = 0; i < 2500; i++) begin
      case (i % 4)
        0: begin ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); end
        1: begin ra = ra ^ (16'h1 << $urandom_range(15)); rc = ~rc; end
        2: begin rb = rb ^ (16'h1 << $urandom_range(15)); end
        default: begin ra = 16'($urandom); rb = ~ra ^ (16'h1 << $urandom_range(15));
                       rc = 1'($urandom); end
      endcase
      drive(1'b0, ra, rb, rc);
      exp_v = exp_q.pop_front();
      vectors++;
      if ({c_16, s} !== exp_v) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got c_16=%b s=%h, want %h", i, c_16, s, exp_v);
      end
    end
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    vectors++;
    if ({c_16, s} !== exp_v) begin
      miscompares++;
      $display("FAIL back_to_back_last: got c_16=%b s=%h, want %h", c_16, s, exp_v);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    c_0 = 1'b0;
    test_reset();
    test_directed();
    test_reset_release();
    test_back_to_back();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/carry_lookahead_16.md
CARRY_LOOKAHEAD_16 -- requirements
Module: carry_lookahead_16

Interface
REQ-001 Parameters: none; width fixed at 16 bits, group size fixed at 4 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports named as follows.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous to clk.
REQ-005 a  input  16  addend A, unsigned.
REQ-006 b  input  16  addend B, unsigned.
REQ-007 c_0  input  1  carry-in.
REQ-008 s  output  16  registered sum, bits 15:0.
REQ-009 c_16  output  1  registered carry-out, sum bit 16.

Function
REQ-010 {c_16, s} SHALL equal a + b + c_0 as a 17-bit unsigned result; there is no truncation or saturation.
REQ-011 Latency SHALL be exactly 1 cycle: operands sampled at clock edge N appear on s/c_16 after edge N.
REQ-012 A new operand set SHALL be accepted every cycle; there is no handshake and no stall.
REQ-013 Per-bit propagate SHALL be p[i] = a[i] XOR b[i]; generate SHALL be g[i] = a[i] AND b[i]; s[i] = p[i] XOR c[i].
REQ-014 Carries inside each 4-bit group SHALL be computed by lookahead equations from p, g and the group carry-in, with no bit-to-bit ripple.
REQ-015 Group carries c4, c8, c12, c16 SHALL be computed by a second-level lookahead from group P/G and c_0, with no group-to-group ripple.
REQ-016 Group propagate SHALL be P = p3&p2&p1&p0; group generate SHALL be G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
REQ-017 Full propagate chain (a ^ b = 0xFFFF, c_0 = 1) SHALL produce s = 0x0000 and c_16 = 1 in the same single-cycle latency.
REQ-018 Wrap-around (0xFFFF + 0x0001) SHALL give s = 0x0000 and c_16 = 1.
REQ-019 Outputs SHALL hold their last registered value only while inputs are unchanged; there is no enable.

Reset
REQ-020 While rst = 1 at a rising edge, s SHALL become 0x0000 and c_16 SHALL become 0.
REQ-021 Reset SHALL take priority over the arithmetic result in the same edge.
REQ-022 At the first edge with rst = 0, outputs SHALL reflect the inputs sampled at that edge.
REQ-023 Reset asserted mid-stream SHALL discard the in-flight result; there is no other state.

Structure
REQ-024 Shared package SHALL hold WIDTH = 16 and GROUP = 4 constants.
REQ-025 Sub-module cla_4bit SHALL implement one 4-bit group, with inputs a[3:0], b[3:0], cin and outputs sum[3:0], P, G; it is instantiated 4 times.
REQ-026 The top level SHALL contain the second-level lookahead carry logic and the output registers only.
REQ-027 The datapath SHALL be purely combinational up to the single output register stage.

Verification
REQ-028 rst = 1 with a = 0x1234, b = 0x1111 -> s = 0x0000, c_16 = 0 after the edge.
REQ-029 a = 0x0000, b = 0x0000, c_0 = 0 -> s = 0x0000, c_16 = 0 one cycle later.
REQ-030 a = 0xFFFF, b = 0x0000, c_0 = 1 -> s = 0x0000, c_16 = 1 (full propagate chain).
REQ-031 a = 0xFFFF, b = 0xFFFF, c_0 = 1 -> s = 0xFFFF, c_16 = 1.
REQ-032 a = 0x0F0F, b = 0x00F1, c_0 = 0 -> s = 0x1000, c_16 = 0 (cross-group carry).
REQ-033 Back-to-back random operands every cycle for ≥2000 cycles, including independently toggling bits of a, b and c_0 -> each output equals the 17-bit reference sum of the previous cycle's inputs.
